// File: rtl/scan_packet_driver_if.sv
// Chip-side scan bus between the packet driver (master) and the scan chain (slave).
interface scan_packet_driver_if;
    logic scan_clk;
    logic scan_en;
    logic scan_out;
    logic sram_load;
    logic scan_in;

    modport master (
        output scan_clk, scan_en, scan_out, sram_load,
        input  scan_in
    );

    modport slave (
        input  scan_clk, scan_en, scan_out, sram_load,
        output scan_in
    );
endinterface

// File: rtl/scan_packet_driver.sv
// Shifts one packet into a chip scan chain, pulses an SRAM load, shifts the chain back out.
// Define SCAN_CHECK_EN to compare the readback against exp under exp_mask.
module scan_packet_driver #(
    parameter int SCAN_W  = 112,
    parameter int CLK_DIV = 4
) (
    input  logic                 clk,
    input  logic                 resetn,
    input  logic                 start,
    input  logic [SCAN_W-1:0]    pkt,
    input  logic [SCAN_W-1:0]    exp,
    input  logic [SCAN_W-1:0]    exp_mask,
    scan_packet_driver_if.master scan,
    output logic                 busy,
    output logic                 done,
    output logic                 mismatch,
    output logic [SCAN_W-1:0]    rdata
);
    localparam int CNT_W = $clog2(SCAN_W + 1);

    typedef enum logic [2:0] {IDLE, SHIFT_IN, LOAD, SHIFT_OUT, CHECK} state_t;

    state_t            state_q, state_d;
    logic [7:0]        div_q, div_d;
    logic [CNT_W-1:0]  bit_q, bit_d;
    logic              sclk_q, sclk_d;
    logic              sen_q, sen_d;
    logic              sout_q, sout_d;
    logic              sload_q, sload_d;
    logic              busy_q, busy_d;
    logic              done_q, done_d;
    logic [SCAN_W-1:0] rdata_q, rdata_d;
    logic [SCAN_W-1:0] shreg_q, shreg_d;
    logic [SCAN_W-1:0] shl;
    logic              tick, rise, fall, last;

`ifdef SCAN_CHECK_EN
    logic [SCAN_W-1:0] exp_q, exp_d;
    logic [SCAN_W-1:0] mask_q, mask_d;
    logic              mism_q, mism_d;
`else
    logic              unused_ops;
    assign unused_ops = ^{exp, exp_mask};
`endif

    // tick marks the last clk of a scan_clk half-period; rise/fall name the edge it produces
    assign tick = (div_q == 8'(CLK_DIV - 1));
    assign rise = tick && !sclk_q;
    assign fall = tick && sclk_q;
    assign last = (bit_q == CNT_W'(SCAN_W - 1));
    assign shl  = shreg_q << 1;

    always_comb begin
        state_d = state_q;
        div_d   = div_q;
        bit_d   = bit_q;
        sclk_d  = sclk_q;
        sen_d   = sen_q;
        sout_d  = sout_q;
        sload_d = sload_q;
        busy_d  = busy_q;
        done_d  = 1'b0;
        rdata_d = rdata_q;
        shreg_d = shreg_q;
`ifdef SCAN_CHECK_EN
        exp_d   = exp_q;
        mask_d  = mask_q;
        mism_d  = mism_q;
`endif
        if (state_q inside {SHIFT_IN, LOAD, SHIFT_OUT}) begin
            div_d = tick ? 8'd0 : div_q + 8'd1;
            if (tick) sclk_d = !sclk_q;
        end

        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = SHIFT_IN;
                    busy_d  = 1'b1;
                    sen_d   = 1'b1;
                    sout_d  = pkt[SCAN_W-1];
                    shreg_d = pkt;
                    div_d   = 8'd0;
                    bit_d   = '0;
`ifdef SCAN_CHECK_EN
                    exp_d   = exp;
                    mask_d  = exp_mask;
`endif
                end
            end
            SHIFT_IN: begin
                // the chip samples on the rising edge, so data moves on the falling edge
                if (fall) begin
                    if (last) begin
                        state_d = LOAD;
                        sen_d   = 1'b0;
                        sload_d = 1'b1;
                        sout_d  = 1'b0;
                        bit_d   = '0;
                    end else begin
                        bit_d   = bit_q + CNT_W'(1);
                        shreg_d = shl;
                        sout_d  = shl[SCAN_W-1];
                    end
                end
            end
            LOAD: begin
                if (fall) begin
                    state_d = SHIFT_OUT;
                    sload_d = 1'b0;
                    sen_d   = 1'b1;
                    sout_d  = 1'b0;
                end
            end
            SHIFT_OUT: begin
                if (rise) rdata_d = (rdata_q << 1) | SCAN_W'(scan.scan_in);
                if (fall) begin
                    if (last) begin
                        state_d = CHECK;
                        sen_d   = 1'b0;
                        bit_d   = '0;
                    end else begin
                        bit_d   = bit_q + CNT_W'(1);
                    end
                end
            end
            CHECK: begin
                state_d = IDLE;
                busy_d  = 1'b0;
                done_d  = 1'b1;
`ifdef SCAN_CHECK_EN
                mism_d  = |((rdata_q ^ exp_q) & mask_q);
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state_q <= IDLE;
            div_q   <= '0;
            bit_q   <= '0;
            sclk_q  <= 1'b0;
            sen_q   <= 1'b0;
            sout_q  <= 1'b0;
            sload_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            rdata_q <= '0;
`ifdef SCAN_CHECK_EN
            mism_q  <= 1'b0;
`endif
        end else begin
            state_q <= state_d;
            div_q   <= div_d;
            bit_q   <= bit_d;
            sclk_q  <= sclk_d;
            sen_q   <= sen_d;
            sout_q  <= sout_d;
            sload_q <= sload_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            rdata_q <= rdata_d;
`ifdef SCAN_CHECK_EN
            mism_q  <= mism_d;
`endif
        end
    end

    // operand registers are only meaningful after a start, so they carry no reset
    always_ff @(posedge clk) begin
        shreg_q <= shreg_d;
`ifdef SCAN_CHECK_EN
        exp_q   <= exp_d;
        mask_q  <= mask_d;
`endif
    end

    assign scan.scan_clk  = sclk_q;
    assign scan.scan_en   = sen_q;
    assign scan.scan_out  = sout_q;
    assign scan.sram_load = sload_q;
    assign busy           = busy_q;
    assign done           = done_q;
    assign rdata          = rdata_q;
`ifdef SCAN_CHECK_EN
    assign mismatch       = mism_q;
`else
    assign mismatch       = 1'b0;
`endif
endmodule

// File: tb/tb_scan_packet_driver.sv
// Scoreboard bench: two driver instances (8-bit/div 2 and 112-bit/div 1) each looped through a chain model.
module tb_scan_packet_driver;
`ifdef SCAN_CHECK_EN
    localparam bit CHK_ON = 1'b1;
`else
    localparam bit CHK_ON = 1'b0;
`endif

    typedef struct {
        logic [127:0] rd;
        logic         mm;
        int           t0;
    } exp_t;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic         resetn;
    logic         start8, busy8, done8, mism8;
    logic [7:0]   pkt8, exp8, mask8, rdata8;
    logic         start112, busy112, done112, mism112;
    logic [111:0] pkt112, exp112, mask112, rdata112;

    scan_packet_driver_if if8();
    scan_packet_driver_if if112();

    scan_packet_driver #(.SCAN_W(8), .CLK_DIV(2)) u8 (
        .clk(clk), .resetn(resetn), .start(start8), .pkt(pkt8), .exp(exp8),
        .exp_mask(mask8), .scan(if8), .busy(busy8), .done(done8),
        .mismatch(mism8), .rdata(rdata8)
    );

    scan_packet_driver #(.SCAN_W(112), .CLK_DIV(1)) u112 (
        .clk(clk), .resetn(resetn), .start(start112), .pkt(pkt112), .exp(exp112),
        .exp_mask(mask112), .scan(if112), .busy(busy112), .done(done112),
        .mismatch(mism112), .rdata(rdata112)
    );

    // chip chain models; force8 makes the SRAM load overwrite the chain with pat8
    logic [7:0]   chain8, pat8;
    logic         force8;
    logic [111:0] chain112;
    assign if8.scan_in   = chain8[7];
    assign if112.scan_in = chain112[111];

    always @(posedge if8.scan_clk) begin
        if (if8.sram_load && force8) chain8 <= pat8;
        else if (if8.scan_en)        chain8 <= {chain8[6:0], if8.scan_out};
    end

    always @(posedge if112.scan_clk) begin
        if (if112.scan_en) chain112 <= {chain112[110:0], if112.scan_out};
    end

    int total = 0;
    int bad   = 0;
    int cyc   = 0;
    always @(posedge clk) cyc <= cyc + 1;

    exp_t sb8[$];
    exp_t sb112[$];

    task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] want);
        total++;
        if (act !== want) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", nm, act, want);
        end
    endtask

    int rtot8, rin8, rld8, redg8;
    logic pb8, ps8;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                rtot8 = 0; rin8 = 0; rld8 = 0; redg8 = 0; pb8 = 1'b0; ps8 = 1'b0;
            end else begin
                if (busy8 && !pb8) begin
                    rtot8 = 0; rin8 = 0; rld8 = 0; redg8 = 0;
                end
                if (if8.scan_clk != ps8) redg8++;
                if (if8.scan_clk && !ps8) begin
                    rtot8++;
                    if (if8.sram_load) rld8++;
                    else if (if8.scan_en && rld8 == 0) rin8++;
                end
                if (done8) begin
                    if (sb8.size() == 0) begin
                        total++; bad++;
                        $display("FAIL done8_unexpected: got done with empty scoreboard, want none");
                    end else begin
                        e = sb8.pop_front();
                        chk("rdata8", 128'(rdata8), e.rd);
                        chk("mismatch8", 128'(mism8), 128'(e.mm));
                        chk("latency8", 128'(cyc - e.t0), 128'(70));
                        chk("rises_shift_in8", 128'(rin8), 128'(8));
                        chk("rises_load8", 128'(rld8), 128'(1));
                        chk("rises_total8", 128'(rtot8), 128'(17));
                        chk("edges8", 128'(redg8), 128'(34));
                    end
                end
                pb8 = busy8;
                ps8 = if8.scan_clk;
            end
        end
    end

    int rtot112, rin112, rld112, redg112;
    logic pb112, ps112;
    initial begin
        exp_t e;
        forever begin
            @(negedge clk);
            if (!resetn) begin
                rtot112 = 0; rin112 = 0; rld112 = 0; redg112 = 0; pb112 = 1'b0; ps112 = 1'b0;
            end else begin
                if (busy112 && !pb112) begin
                    rtot112 = 0; rin112 = 0; rld112 = 0; redg112 = 0;
                end
                if (if112.scan_clk != ps112) redg112++;
                if (if112.scan_clk && !ps112) begin
                    rtot112++;
                    if (if112.sram_load) rld112++;
                    else if (if112.scan_en && rld112 == 0) rin112++;
                end
                if (done112) begin
                    if (sb112.size() == 0) begin
                        total++; bad++;
                        $display("FAIL done112_unexpected: got done with empty scoreboard, want none");
                    end else begin
                        e = sb112.pop_front();
                        chk("rdata112", 128'(rdata112), e.rd);
                        chk("mismatch112", 128'(mism112), 128'(e.mm));
                        chk("latency112", 128'(cyc - e.t0), 128'(452));
                        chk("rises_shift_in112", 128'(rin112), 128'(112));
                        chk("rises_load112", 128'(rld112), 128'(1));
                        chk("rises_total112", 128'(rtot112), 128'(225));
                        chk("edges112", 128'(redg112), 128'(450));
                    end
                end
                pb112 = busy112;
                ps112 = if112.scan_clk;
            end
        end
    end

    task automatic run8(input logic [7:0] p, input logic [7:0] e, input logic [7:0] m,
                        input bit frc, input logic [7:0] pat,
                        input logic [7:0] want_rd, input logic want_mm, input bit dbl);
        exp_t x;
        force8 = frc;
        pat8   = pat;
        pkt8   = p;
        exp8   = e;
        mask8  = m;
        start8 = 1'b1;
        x.rd = 128'(want_rd);
        x.mm = want_mm;
        x.t0 = cyc;
        sb8.push_back(x);
        @(negedge clk);
        start8 = 1'b0;
        if (dbl) begin
            repeat (10) @(negedge clk);
            pkt8   = 8'h0F;
            exp8   = 8'h00;
            start8 = 1'b1;
            @(negedge clk);
            start8 = 1'b0;
        end
        for (int i = 0; i < 200 && busy8; i++) @(negedge clk);
        chk("idle8", 128'(busy8), 128'(0));
        repeat (3) @(negedge clk);
        if (dbl) chk("second_start_ignored", 128'(busy8), 128'(0));
    endtask

    task automatic run112(input logic [111:0] p, input logic [111:0] e, input logic want_mm);
        exp_t x;
        pkt112   = p;
        exp112   = e;
        mask112  = '1;
        start112 = 1'b1;
        x.rd = 128'(p);
        x.mm = want_mm;
        x.t0 = cyc;
        sb112.push_back(x);
        @(negedge clk);
        start112 = 1'b0;
        for (int i = 0; i < 600 && busy112; i++) @(negedge clk);
        chk("idle112", 128'(busy112), 128'(0));
        repeat (3) @(negedge clk);
    endtask

    initial begin
        #400us;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [127:0] r;
        resetn = 1'b0;
        start8 = 1'b0; pkt8 = '0; exp8 = '0; mask8 = '0; force8 = 1'b0; pat8 = '0;
        start112 = 1'b0; pkt112 = '0; exp112 = '0; mask112 = '0;
        repeat (3) @(negedge clk);
        chk("reset_ctl8", 128'({if8.scan_clk, if8.scan_en, if8.scan_out, if8.sram_load,
                                busy8, done8, mism8}), 128'(0));
        chk("reset_rdata8", 128'(rdata8), 128'(0));
        chk("reset_ctl112", 128'({if112.scan_clk, if112.scan_en, if112.scan_out, if112.sram_load,
                                  busy112, done112, mism112}), 128'(0));
        chk("reset_rdata112", 128'(rdata112), 128'(0));
        resetn = 1'b1;
        @(negedge clk);

        run8(8'hA5, 8'hA5, 8'hFF, 1'b0, 8'h00, 8'hA5, 1'b0, 1'b0);
        run8(8'h01, 8'h00, 8'h01, 1'b0, 8'h00, 8'h01, CHK_ON, 1'b0);
        run8(8'h3C, 8'h3C, 8'hFF, 1'b0, 8'h00, 8'h3C, 1'b0, 1'b0);
        run8(8'h00, 8'hA5, 8'hFE, 1'b1, 8'hA4, 8'hA4, 1'b0, 1'b0);
        run8(8'h00, 8'hA5, 8'hFF, 1'b1, 8'hA4, 8'hA4, CHK_ON, 1'b0);
        run8(8'h96, 8'h96, 8'hFF, 1'b0, 8'h00, 8'h96, 1'b0, 1'b1);

        // abort in LOAD, then start in the first cycle after release
        force8 = 1'b0;
        pkt8 = 8'h5A; exp8 = 8'h00; mask8 = 8'h00;
        start8 = 1'b1;
        @(negedge clk);
        start8 = 1'b0;
        for (int i = 0; i < 200 && !if8.sram_load; i++) @(negedge clk);
        chk("reach_load", 128'(if8.sram_load), 128'(1));
        #2 resetn = 1'b0;
        #1;
        chk("abort_ctl8", 128'({if8.scan_clk, if8.scan_en, if8.scan_out, if8.sram_load,
                                busy8, done8, mism8}), 128'(0));
        chk("abort_rdata8", 128'(rdata8), 128'(0));
        repeat (3) @(negedge clk);
        resetn = 1'b1;
        run8(8'hC3, 8'hC3, 8'hFF, 1'b0, 8'h00, 8'hC3, 1'b0, 1'b0);

        r = {$urandom, $urandom, $urandom, $urandom};
        run112(r[111:0], r[111:0], 1'b0);
        r = {$urandom, $urandom, $urandom, $urandom};
        run112(r[111:0], r[111:0] ^ 112'h1, CHK_ON);

        chk("scoreboard8_empty", 128'(sb8.size()), 128'(0));
        chk("scoreboard112_empty", 128'(sb112.size()), 128'(0));
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/scan_packet_driver.md
SCAN_PACKET_DRIVER -- requirements
Module: scan_packet_driver

Interface
REQ-001 SHALL have parameter SCAN_W, default 112, scan-chain length in bits.
REQ-002 SHALL have parameter CLK_DIV, default 4, clk cycles per scan_clk half-period (legal 1..255).
REQ-003 SHALL have port clk  input  1  single block clock.
REQ-004 SHALL have port resetn  input  1  reset, asynchronous, active-low.
REQ-005 SHALL have port start  input  1  one-cycle request to run one packet.
REQ-006 SHALL have port pkt  input  SCAN_W  packet to shift into the chip chain.
REQ-007 SHALL have port exp  input  SCAN_W  expected readback.
REQ-008 SHALL have port exp_mask  input  SCAN_W  compare mask (1 = compare bit).
REQ-009 SHALL have port scan_in  input  1  serial data from chip (gpio_out).
REQ-010 SHALL have port scan_clk  output  1  scan clock to chip (gpio_clk).
REQ-011 SHALL have port scan_en  output  1  chain shift enable (gpio_scan).
REQ-012 SHALL have port scan_out  output  1  serial data to chip (gpio_in).
REQ-013 SHALL have port sram_load  output  1  SRAM operation strobe (gpio_sram_load).
REQ-014 SHALL have ports busy, done, mismatch  output  1 each  status.
REQ-015 SHALL have port rdata  output  SCAN_W  captured readback vector.

Function
REQ-016 SHALL implement states IDLE, SHIFT_IN, LOAD, SHIFT_OUT, CHECK.
REQ-017 In IDLE, start=1 SHALL latch pkt/exp/exp_mask and enter SHIFT_IN next cycle; busy=1 in every non-IDLE state.
REQ-018 start while busy=1 SHALL be ignored; latched operands SHALL not change.
REQ-019 Bit period = 2*CLK_DIV clk cycles: scan_clk low CLK_DIV cycles, then high CLK_DIV cycles; scan_clk SHALL be 0 in IDLE and CHECK.
REQ-020 scan_out SHALL change only on the clk edge where scan_clk goes low or at state entry; MSB of pkt first.
REQ-021 SHIFT_IN: scan_en=1 for exactly SCAN_W bit periods, then LOAD.
REQ-022 LOAD: scan_en=0, sram_load=1 for exactly one bit period (one scan_clk rising edge), then SHIFT_OUT.
REQ-023 SHIFT_OUT: scan_en=1, scan_out=0, SCAN_W bit periods; scan_in sampled on the clk edge where scan_clk goes high, shifted into rdata LSB, first sample ending at MSB.
REQ-024 CHECK lasts one cycle; then IDLE with done=1 for exactly that IDLE-entry cycle.
REQ-025 mismatch SHALL update in CHECK to |((rdata ^ exp) & exp_mask) and hold until next CHECK.
REQ-026 Total start-to-done latency SHALL be 1 + (2*SCAN_W+1)*2*CLK_DIV + 1 cycles.
REQ-027 Bit counter SHALL be wide enough for SCAN_W without wrap; no extra or missing scan_clk edges.
REQ-028 rdata SHALL hold its value outside SHIFT_OUT.

Reset
REQ-029 resetn=0 SHALL asynchronously force IDLE; scan_clk, scan_en, scan_out, sram_load, busy, done, mismatch=0; rdata=0.
REQ-030 Reset mid-operation SHALL abort with no done pulse; first cycle after release SHALL accept start.

Configuration
REQ-031 Macro SCAN_CHECK_EN: defined -> compare per REQ-025; undefined -> no compare logic, exp/exp_mask unused, mismatch tied 0, CHECK still one cycle, rdata still captured.

Verification
REQ-032 SCAN_W=8, CLK_DIV=2, pkt=8'hA5, scan_in looped from scan_out delayed 8 bits -> 8 scan_clk rises with scan_en=1, 1 with sram_load=1, rdata=8'hA5, done at cycle 70.
REQ-033 SCAN_CHECK_EN, exp=8'hA5, mask=8'hFF, scan_in forced to 8'hA4 pattern -> mismatch=1; mask=8'hFE -> mismatch=0.
REQ-034 Second start pulsed mid SHIFT_IN -> ignored, single done, latency unchanged.
REQ-035 resetn low during LOAD -> all outputs 0 immediately, no done; new start completes normally.
REQ-036 CLK_DIV=1, SCAN_W=112, random pkt -> scan_clk toggles every cycle, exactly 225 rising edges, rdata equals chain model.
